// File: rtl/cnet_dma_rx.sv
// CNET->CPCI DMA receiver: round-robin MAC fetch into a one-packet FIFO,
// then first-word fall-through read-out to the PCI DMA master.
module cnet_dma_rx #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_ADDR_BITS = 9,
  parameter int MAX_PKT_BYTES  = 2048,
  parameter int NF_MARGIN      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            cpci_dma_pkt_avail,
  output logic [3:0]            cpci_dma_send,
  input  logic                  cpci_dma_wr_en,
  input  logic [DATA_WIDTH-1:0] cpci_dma_data,
  output logic                  cpci_dma_nearly_full,
  input  logic                  dma_rx_enable,
  output logic                  rx_pkt_ready,
  output logic [11:0]           rx_pkt_len,
  output logic [1:0]            rx_pkt_mac,
  input  logic                  rx_rd_en,
  output logic [DATA_WIDTH-1:0] rx_rd_data,
  output logic                  rx_rd_last,
  output logic                  rx_err_len,
  output logic                  rx_err_timeout,
  output logic                  rx_err_unexpected
);

  localparam int DEPTH = 2 ** FIFO_ADDR_BITS;
  localparam int FW    = FIFO_ADDR_BITS + 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND    = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_READY   = 3'd4;
  localparam logic [2:0] S_DISCARD = 3'd5;

  logic [2:0]                state;
  logic [1:0]                ptr, mac, pick, idx;
  logic                      pick_ok;
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0]             fill, fill_nx, words, dcnt;
  logic [FW:0]               free_nx;
  logic [TW-1:0]             tmr;
  logic [11:0]               wlen;
  logic                      do_wr, do_rd, flush, len_ok, xfer, nf_nx;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  // first requester strictly after the last-served MAC wins
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (cpci_dma_pkt_avail[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  assign len_ok  = (cpci_dma_data != '0) &&
                   (cpci_dma_data <= DATA_WIDTH'(MAX_PKT_BYTES));
  assign wlen    = (cpci_dma_data[11:0] + 12'd3) >> 2;
  assign xfer    = (state == S_LEN) || (state == S_DATA);
  assign flush   = xfer && !cpci_dma_wr_en &&
                   (tmr == TW'(TIMEOUT_CYCLES - 1));
  assign do_wr   = (state == S_DATA) && cpci_dma_wr_en &&
                   (fill != FW'(DEPTH));
  assign do_rd   = (state == S_READY) && rx_rd_en && (fill != '0);
  assign fill_nx = flush ? '0 : fill + FW'(do_wr) - FW'(do_rd);
  assign free_nx = (FW+1)'(DEPTH) - {1'b0, fill_nx};
  assign nf_nx   = free_nx <= (FW+1)'(NF_MARGIN);

  assign rx_pkt_ready  = (state == S_READY);
  assign cpci_dma_send = (state == S_SEND) ? (4'b0001 << mac) : 4'b0000;
  assign rx_rd_data    = rx_pkt_ready ? mem[rd_ptr] : '0;
  assign rx_rd_last    = rx_pkt_ready && (fill == FW'(1));

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= cpci_dma_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= S_IDLE;
      ptr                  <= 2'd3;
      mac                  <= '0;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      fill                 <= '0;
      words                <= '0;
      dcnt                 <= '0;
      tmr                  <= '0;
      rx_pkt_len           <= '0;
      rx_pkt_mac           <= '0;
      cpci_dma_nearly_full <= 1'b0;
      rx_err_len           <= 1'b0;
      rx_err_timeout       <= 1'b0;
      rx_err_unexpected    <= 1'b0;
    end else begin
      rx_err_len           <= 1'b0;
      rx_err_timeout       <= 1'b0;
      rx_err_unexpected    <= 1'b0;
      fill                 <= fill_nx;
      cpci_dma_nearly_full <= nf_nx;
      wr_ptr <= flush ? '0 : wr_ptr + FIFO_ADDR_BITS'(do_wr);
      rd_ptr <= flush ? '0 : rd_ptr + FIFO_ADDR_BITS'(do_rd);
      case (state)
        S_IDLE: begin
          if (cpci_dma_wr_en) rx_err_unexpected <= 1'b1;
          if (dma_rx_enable && pick_ok) begin
            mac   <= pick;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (cpci_dma_wr_en) rx_err_unexpected <= 1'b1;
          ptr   <= mac;
          tmr   <= '0;
          state <= S_LEN;
        end
        S_LEN: begin
          if (cpci_dma_wr_en) begin
            tmr <= '0;
            if (len_ok) begin
              rx_pkt_len <= cpci_dma_data[11:0];
              rx_pkt_mac <= mac;
              words      <= wlen[FW-1:0];
              dcnt       <= '0;
              state      <= S_DATA;
            end else begin
              rx_err_len <= 1'b1;
              state      <= S_DISCARD;
            end
          end else if (flush) begin
            rx_err_timeout <= 1'b1;
            state          <= S_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_DATA: begin
          if (cpci_dma_wr_en) begin
            tmr <= '0;
            // a full FIFO drops the word but still counts it
            if (!do_wr) rx_err_unexpected <= 1'b1;
            dcnt <= dcnt + FW'(1);
            if ((dcnt + FW'(1)) == words) state <= S_READY;
          end else if (flush) begin
            rx_err_timeout <= 1'b1;
            state          <= S_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_READY: begin
          if (cpci_dma_wr_en) rx_err_unexpected <= 1'b1;
          if (do_rd && (fill == FW'(1))) state <= S_IDLE;
        end
        S_DISCARD: begin
          if (!cpci_dma_wr_en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
